// File: rtl/amp_i2c_pkg.sv
// Shared types and widths for the amp I2C write arbiter.
// FSM state encoding plus register-address and data widths.
package amp_i2c_pkg;

  localparam int I2C_REG_AW = 7;
  localparam int I2C_DW     = 8;
  localparam int TMO_W      = 12;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP
  } arb_state_t;

endpackage

// File: rtl/amp_rr_arb.sv
// Combinational NREQ-way round-robin picker.
// Priority starts at rr_ptr and wraps from NREQ-1 back to 0.
module amp_rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(rr_ptr) + k) % NREQ);
      if (!valid && req[j]) begin
        valid    = 1'b1;
        idx      = j;
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/amp_i2c_arbiter.sv
// Round-robin arbiter sharing one amp I2C byte-write engine.
// Define AMP_I2C_NACK_RETRY_EN to retry NACKed writes up to MAX_RETRY.
module amp_i2c_arbiter
  import amp_i2c_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int GAP_CYC   = 16,
  parameter int TIMEOUT   = 4095,
  parameter int MAX_RETRY = 2
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic [NREQ-1:0]            req,
  input  logic [I2C_REG_AW*NREQ-1:0] req_addr,
  input  logic [I2C_DW*NREQ-1:0]     req_data,
  output logic [NREQ-1:0]            ack,
  output logic [NREQ-1:0]            err,
  output logic                       tx_start,
  output logic [I2C_REG_AW-1:0]      tx_addr,
  output logic [I2C_DW-1:0]          tx_data,
  input  logic                       tx_done,
  input  logic                       tx_nack,
  output logic                       busy
);

  localparam int IW = $clog2(NREQ);
  localparam int GW = $clog2(GAP_CYC + 1);

  if (NREQ < 2 || NREQ > 8 || GAP_CYC < 1 ||
      TIMEOUT < 1 || TIMEOUT > 4095 ||
      MAX_RETRY < 0) begin : g_bad_cfg
    $error("amp_i2c_arbiter: bad parameters");
  end

  arb_state_t state, state_nxt;

  logic [IW-1:0]         rr_ptr, g_idx;
  logic [IW-1:0]         arb_idx, ptr_nxt;
  logic [NREQ-1:0]       g_oh, arb_grant;
  logic                  arb_valid;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [GW-1:0]         gap_cnt;
  logic                  tmo_hit, gap_last;
  logic                  wait_exit, new_grant;
  logic                  retry_q, retry_nack;
  logic [I2C_REG_AW-1:0] addr_a [NREQ];
  logic [I2C_DW-1:0]     data_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*I2C_REG_AW +: I2C_REG_AW];
    assign data_a[i] = req_data[i*I2C_DW +: I2C_DW];
  end

  amp_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (arb_grant),
    .idx    (arb_idx),
    .valid  (arb_valid)
  );

  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign gap_last  = (gap_cnt == GW'(GAP_CYC - 1));
  assign wait_exit = tx_done || tmo_hit;
  // A pending retry owns the engine; arbitration is skipped.
  assign new_grant = (state == IDLE) && !retry_q && arb_valid;
  assign ptr_nxt   = (g_idx == IW'(NREQ - 1)) ?
                     '0 : g_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (retry_q || arb_valid) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (wait_exit) state_nxt = GAP;
      GAP:   if (gap_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_start = 1'b0;
    busy     = 1'b1;
    unique case (state)
      IDLE:    busy = 1'b0;
      ISSUE:   tx_start = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      rr_ptr  <= '0;
      g_idx   <= '0;
      g_oh    <= '0;
      tx_addr <= '0;
      tx_data <= '0;
      tmo_cnt <= '0;
      gap_cnt <= '0;
      ack     <= '0;
      err     <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      unique case (state)
        IDLE: begin
          if (new_grant) begin
            g_idx   <= arb_idx;
            g_oh    <= arb_grant;
            tx_addr <= addr_a[arb_idx];
            tx_data <= data_a[arb_idx];
          end
        end
        ISSUE: tmo_cnt <= '0;
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          gap_cnt <= '0;
          if (wait_exit) begin
            rr_ptr <= ptr_nxt;
            if (tx_done && !tx_nack) ack <= g_oh;
            else if (!retry_nack)    err <= g_oh;
          end
        end
        GAP: gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef AMP_I2C_NACK_RETRY_EN
  localparam int RCW = (MAX_RETRY < 1) ?
                       1 : $clog2(MAX_RETRY + 1);

  logic [RCW-1:0] retry_cnt;

  // Timeouts never retry: retry_nack needs a real tx_done.
  assign retry_nack = tx_done && tx_nack &&
                      (int'(retry_cnt) < MAX_RETRY);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      retry_cnt <= '0;
      retry_q   <= 1'b0;
    end else if (new_grant) begin
      retry_cnt <= '0;
      retry_q   <= 1'b0;
    end else if (state == WAIT && wait_exit) begin
      retry_q <= retry_nack;
      if (retry_nack) retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  assign retry_nack = 1'b0;
  assign retry_q    = 1'b0;
`endif

endmodule

// File: tb/tb_amp_i2c_arbiter.sv
// Scoreboard bench for amp_i2c_arbiter with random requesters.
// Engine responder and output monitor run as separate processes.
module tb_amp_i2c_arbiter;

  localparam int NREQ = 4;
  localparam int GAP  = 16;
  localparam int TMO  = 4095;
  localparam int MR   = 2;
`ifdef AMP_I2C_NACK_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } tx_t;

  typedef struct packed {
    logic [1:0] idx;
    logic       is_err;
    logic       tmo;
  } rsp_t;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic [3:0]  req = '0;
  logic [27:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack, err;
  logic        tx_start;
  logic [6:0]  tx_addr;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        tx_nack = 1'b0;
  logic        busy;

  tx_t  tx_q  [$];
  rsp_t rsp_q [$];
  bit   eng_q [$];

  int   n_pass = 0, n_tot = 0;
  int   cyc = 0, eng_done_cyc = 0, last_start = 0;
  int   n_starts = 0, ptr = 0;
  int   eng_delay = 0;
  bit   gap_valid = 1'b0, eng_silent = 1'b0;
  logic [6:0] a_addr [4];
  logic [7:0] a_data [4];
  int         nk_plan [4];

  amp_i2c_arbiter #(
    .NREQ(NREQ), .GAP_CYC(GAP),
    .TIMEOUT(TMO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .resetb(resetb),
    .req(req), .req_addr(req_addr),
    .req_data(req_data),
    .ack(ack), .err(err),
    .tx_start(tx_start),
    .tx_addr(tx_addr), .tx_data(tx_data),
    .tx_done(tx_done), .tx_nack(tx_nack),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h t=%0t",
                  nm, got, want, $time);
  endtask

  task automatic fail_now(input string nm);
    n_tot++;
    $display("FAIL %s t=%0t", nm, $time);
  endtask

  // Monitor: pop expectations whenever the DUT shows an output.
  always @(negedge clk) begin
    if (resetb) begin
      if (tx_start) begin
        tx_t e;
        n_starts++;
        last_start = cyc;
        if (gap_valid)
          chk("gap_min", 32'(cyc - eng_done_cyc >= GAP + 2), 1);
        if (tx_q.size() == 0) fail_now("unexpected_tx_start");
        else begin
          e = tx_q.pop_front();
          chk("tx_addr", 32'(tx_addr), 32'(e.addr));
          chk("tx_data", 32'(tx_data), 32'(e.data));
        end
      end
      if (|ack || |err) begin
        rsp_t r;
        logic [3:0] oh;
        if (rsp_q.size() == 0) begin
          $display("FAIL unexpected_resp ack=%b err=%b", ack, err);
          n_tot++;
        end else begin
          r  = rsp_q.pop_front();
          oh = 4'b0001 << r.idx;
          chk("ack", 32'(ack), r.is_err ? 32'd0 : 32'(oh));
          chk("err", 32'(err), r.is_err ? 32'(oh) : 32'd0);
          if (r.tmo)
            chk("tmo_lat", 32'((cyc - last_start >= TMO) &&
                               (cyc - last_start <= TMO + 1)), 1);
          else
            chk("resp_lat", 32'(cyc), 32'(eng_done_cyc + 1));
        end
      end
    end
  end

  // Engine model: answer each tx_start after a delay.
  initial begin
    forever begin
      @(negedge clk);
      if (resetb && tx_start && !eng_silent) begin
        bit nk;
        int d;
        nk = (eng_q.size() != 0) ? eng_q.pop_front() : 1'b0;
        d  = (eng_delay != 0) ? eng_delay : int'($urandom_range(1, 20));
        repeat (d) @(posedge clk);
        #1;
        tx_done = 1'b1;
        tx_nack = nk;
        eng_done_cyc = cyc;
        gap_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        tx_nack = 1'b0;
      end
    end
  end

  task automatic set_plan(input int i, input logic [6:0] ad,
                          input logic [7:0] da, input int nk);
    a_addr[i]  = ad;
    a_data[i]  = da;
    nk_plan[i] = nk;
    req_addr[i*7 +: 7] = ad;
    req_data[i*8 +: 8] = da;
  endtask

  task automatic rand_plan(input int i);
    int nk;
    if (RETRY) nk = int'($urandom_range(0, 3));
    else       nk = ($urandom_range(0, 3) == 0) ? 1 : 0;
    set_plan(i, {5'($urandom), 2'(i)}, 8'($urandom), nk);
  endtask

  // Reference: service order is the requesting set walked from ptr.
  task automatic push_round(input logic [3:0] s);
    int last;
    last = ptr;
    for (int k = 0; k < 4; k++) begin
      int j, ntx;
      tx_t  e;
      rsp_t r;
      j = (ptr + k) % 4;
      if (s[j]) begin
        ntx = RETRY ? ((nk_plan[j] < MR ? nk_plan[j] : MR) + 1) : 1;
        e.addr = a_addr[j];
        e.data = a_data[j];
        for (int t = 0; t < ntx; t++) begin
          tx_q.push_back(e);
          eng_q.push_back(t < nk_plan[j]);
        end
        r.idx    = 2'(j);
        r.is_err = nk_plan[j] > (RETRY ? MR : 0);
        r.tmo    = 1'b0;
        rsp_q.push_back(r);
        last = j;
      end
    end
    ptr = (last + 1) % 4;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now("wait_idle_timeout");
  endtask

  task automatic drive_until_done(input int budget);
    int n;
    n = 0;
    while (req != 0 && n < budget) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < 4; i++)
        if (ack[i] || err[i]) req[i] = 1'b0;
    end
    if (req != 0) begin
      fail_now("req_not_served");
      req = '0;
    end
  endtask

  task automatic stray_done();
    @(posedge clk);
    #1 tx_done = 1'b1;
    @(posedge clk);
    #1 tx_done = 1'b0;
  endtask

  task automatic run_round(input logic [3:0] s);
    wait_idle();
    for (int i = 0; i < 4; i++) if (s[i]) rand_plan(i);
    push_round(s);
    req = s;
    drive_until_done(3000);
  endtask

  initial begin
    logic [3:0] s;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_addr", 32'(tx_addr), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    resetb = 1'b1;

    // All four at once from pointer 0: order 0,1,2,3.
    run_round(4'b1111);

    // Single write, engine completes after 100 cycles.
    wait_idle();
    eng_delay = 100;
    set_plan(1, 7'h40, 8'h18, 0);
    push_round(4'b0010);
    req = 4'b0010;
    drive_until_done(500);
    eng_delay = 0;

    // NACK handling.
    wait_idle();
    set_plan(2, 7'h12, 8'hA5, 3);
    push_round(4'b0100);
    req = 4'b0100;
    drive_until_done(1000);
    wait_idle();
    set_plan(0, 7'h21, 8'h5A, 1);
    push_round(4'b0001);
    req = 4'b0001;
    drive_until_done(1000);

    for (int r = 0; r < 40; r++) begin
      s = 4'($urandom_range(1, 15));
      run_round(s);
    end

    // Pulse req[2] during GAP is lost; held req[3] is served.
    wait_idle();
    rand_plan(0);
    nk_plan[0] = 0;
    push_round(4'b0001);
    req = 4'b0001;
    drive_until_done(500);
    rand_plan(3);
    nk_plan[3] = 0;
    push_round(4'b1000);
    set_plan(2, 7'h33, 8'h44, 0);
    req = 4'b1100;
    @(negedge clk);
    req[2] = 1'b0;
    drive_until_done(500);
    repeat (GAP + 10) @(negedge clk);

    // Timeout: silent engine, then stray tx_done pulses.
    wait_idle();
    eng_silent = 1'b1;
    gap_valid  = 1'b0;
    set_plan(1, 7'h55, 8'h66, 0);
    begin
      tx_t  e;
      rsp_t r;
      e.addr = 7'h55;
      e.data = 8'h66;
      tx_q.push_back(e);
      r.idx = 2'd1;
      r.is_err = 1'b1;
      r.tmo = 1'b1;
      rsp_q.push_back(r);
      ptr = 2;
    end
    req = 4'b0010;
    drive_until_done(TMO + 200);
    stray_done();
    repeat (GAP + 20) @(negedge clk);
    stray_done();
    repeat (5) @(negedge clk);
    chk("idle_after_stray", 32'(busy), 0);
    chk("no_resp_pending", 32'(rsp_q.size()), 0);
    eng_silent = 1'b0;

    // Reset during WAIT, then re-grant from pointer 0.
    wait_idle();
    eng_silent = 1'b1;
    set_plan(1, 7'h0B, 8'hC1, 0);
    set_plan(2, 7'h0E, 8'hC2, 0);
    push_round(4'b0110);
    n = n_starts;
    req = 4'b0110;
    for (int w = 0; w < 50 && n_starts == n; w++)
      @(negedge clk);
    if (n_starts == n) fail_now("no_start_before_reset");
    repeat (10) @(negedge clk);
    resetb = 1'b0;
    @(negedge clk);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_tx_start", 32'(tx_start), 0);
    tx_q.delete();
    rsp_q.delete();
    eng_q.delete();
    ptr = 0;
    gap_valid  = 1'b0;
    eng_silent = 1'b0;
    resetb = 1'b1;
    push_round(4'b0110);
    drive_until_done(1000);

    repeat (GAP + 10) @(negedge clk);
    chk("final_tx_q_empty", 32'(tx_q.size()), 0);
    chk("final_rsp_q_empty", 32'(rsp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
